hazard_stall_sequencer: RTL
===========================

# hazard_stall_sequencer

Sequencing controller for the pipeline front end. It takes raw hazard indications from hazard detection and the EX-stage multiply/divide unit and drives the IF/ID/EX write enables, the control-bubble select and the IF/ID flush. It adds a multi-cycle freeze for the multiply/divide unit and a watchdog on stalls that run too long. It sits between the hazard detector and the PC, IF/ID and ID/EX pipeline registers.

## Interface
- MDU_LATENCY, 4: number of freeze cycles after a mult/div enters EX; 0 disables the freeze.
- STALL_MAX, 8: consecutive data/jr stall cycles that set the watchdog error; must be at least 1.
- CNT_W, 16: width of the performance counters.
- Clk  in  1  pipeline clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- jr_pending  in  1  jr in ID whose Rs is still in flight.
- data_hazard  in  1  RAW hazard between ID sources and an in-flight destination.
- ctrl_xfer  in  1  jump, taken branch or jr resolved in ID this cycle.
- mdu_start  in  1  mult/div instruction in EX this cycle.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- ID_EX_Write  out  1  ID/EX register load enable.
- control  out  1  1 passes decoded control to ID/EX; 0 inserts a bubble.
- IF_ID_flush  out  1  clears the IF/ID register.
- stall_active  out  1  high when PCWrite is 0.
- watchdog_err  out  1  sticky stall-timeout flag.
- stall_cycles  out  CNT_W  count of cycles with PCWrite=0 (macro-dependent).
- flush_count  out  CNT_W  count of cycles with IF_ID_flush=1 (macro-dependent).

## Operation
- There are two states, RUN and MDU_WAIT, plus a down-counter mdu_cnt of width clog2(MDU_LATENCY+1).
- Outputs in RUN are decoded combinationally from the inputs, in this priority order:
  - jr_pending or data_hazard (stall): PCWrite=0, IF_ID_Write=0, ID_EX_Write=1, control=0, IF_ID_flush=0.
  - ctrl_xfer (flush): PCWrite=1, IF_ID_Write=0, ID_EX_Write=1, control=1, IF_ID_flush=1.
  - no condition (normal): all write enables 1, control=1, IF_ID_flush=0.
- RUN to MDU_WAIT: taken when mdu_start=1 at the edge and MDU_LATENCY>0, whatever the RUN sub-case. mdu_cnt is loaded with MDU_LATENCY-1.
- Outputs in MDU_WAIT are fixed:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Write=0.
  - control=1, IF_ID_flush=0.
- mdu_cnt decrements each cycle in MDU_WAIT. The state returns to RUN on the edge where mdu_cnt is 0.
- All inputs are ignored in MDU_WAIT. A frozen ctrl_xfer is presented again when the state returns to RUN.
- Watchdog counter wd_cnt:
  - Increments, saturating at STALL_MAX, on each RUN cycle in the stall sub-case.
  - Clears on any other cycle.
  - watchdog_err sets on the edge where wd_cnt reaches STALL_MAX and stays set until reset.
- stall_active equals the inverse of PCWrite.

## Timing
- RUN outputs have zero-cycle latency from the inputs. MDU_WAIT outputs are registered state only.
- A mult/div sampled at edge N causes a freeze of exactly MDU_LATENCY cycles, starting in cycle N+1.
- The cycle in which mdu_start is high follows normal RUN decode.
- While Rst_n is low:
  - State is RUN, mdu_cnt=0, wd_cnt=0, watchdog_err=0, counters 0.
  - Outputs are forced to PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, control=0, IF_ID_flush=1, stall_active=1.
- Reset asserted during MDU_WAIT aborts the freeze immediately; it is not resumed.
- Inputs asserted together resolve strictly by the RUN priority order. Example: data_hazard with ctrl_xfer produces a stall, with no flush.
- watchdog_err rises in the cycle after the STALL_MAX-th consecutive stall cycle.

## Configuration
- With HAZ_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with PCWrite=0 and Rst_n high.
  - flush_count increments on every cycle with IF_ID_flush=1 and Rst_n high.
  - Both saturate at all-ones.
- Without HAZ_PERF_CNT_EN:
  - Neither counter register is built.
  - stall_cycles and flush_count are tied to 0.

## Test plan
- Reset check:
  - Stimulus: Rst_n low for 3 cycles, then all inputs 0.
  - Required: outputs at the reset values during reset, then 1/1/1/1/0 in the first cycle after release.
- Simultaneous hazard and control transfer:
  - Stimulus: data_hazard=1 and ctrl_xfer=1 in the same cycle.
  - Required: PCWrite=0, control=0, IF_ID_flush=0.
  - Stimulus: ctrl_xfer=1 alone in the next cycle.
  - Required: IF_ID_flush=1, IF_ID_Write=0.
- Multiply/divide freeze:
  - Stimulus: MDU_LATENCY=4, mdu_start pulse at edge N.
  - Required: exactly 4 cycles with PCWrite=ID_EX_Write=0 (N+1 to N+4), normal operation at N+5.
  - Required: a ctrl_xfer held during the freeze produces a flush only at N+5.
- Watchdog:
  - Stimulus: STALL_MAX=8, data_hazard high for 8 cycles, then low.
  - Required: watchdog_err=1 from cycle 9 and stays 1 through 20 more idle cycles.
  - Stimulus: 7 stall cycles, 1 normal cycle, 7 stall cycles.
  - Required: watchdog_err stays 0.
- Reset mid-freeze:
  - Stimulus: Rst_n pulsed low 2 cycles into MDU_WAIT.
  - Required: the freeze ends immediately, and after release the next cycle is normal RUN.
- Performance counters, with HAZ_PERF_CNT_EN defined:
  - Stimulus: 3 stalls, 2 flushes and a 4-cycle freeze.
  - Required: stall_cycles=7, flush_count=2.
  - Without the macro, both counters read 0.

Source files
------------

// File: rtl/hazard_stall_sequencer.sv
// rtl/hazard_stall_sequencer.sv - pipeline front-end stall/flush/freeze sequencer with stall watchdog
// Optional feature macro: HAZ_PERF_CNT_EN (builds the stall_cycles / flush_count counters).
module hazard_stall_sequencer #(
  parameter int MDU_LATENCY = 4,
  parameter int STALL_MAX   = 8,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             jr_pending,
  input  logic             data_hazard,
  input  logic             ctrl_xfer,
  input  logic             mdu_start,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             control,
  output logic             IF_ID_flush,
  output logic             stall_active,
  output logic             watchdog_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // A zero latency still needs a one-bit counter so the declaration stays legal.
  localparam int MCW = (MDU_LATENCY > 0) ? $clog2(MDU_LATENCY + 1) : 1;
  localparam int WDW = $clog2(STALL_MAX + 1);
  localparam logic [MCW-1:0] MDU_LOAD = (MDU_LATENCY > 0) ? MCW'(MDU_LATENCY - 1) : '0;
  localparam logic [WDW-1:0] WD_MAX   = WDW'(STALL_MAX);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [MCW-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
  logic             watchdog_err_q, watchdog_err_d;
  logic             stall_case;

  // Stall sub-case only exists in RUN; MDU_WAIT ignores every input.
  assign stall_case = (state_q == RUN) && (jr_pending || data_hazard);

  // Output decode: reset forcing first, then the freeze, then RUN priority stall > flush > normal.
  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Write = 1'b1;
    control     = 1'b1;
    IF_ID_flush = 1'b0;
    if (!Rst_n) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      control     = 1'b0;
      IF_ID_flush = 1'b1;
    end else if (state_q == MDU_WAIT) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
    end else if (stall_case) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      control     = 1'b0;
    end else if (ctrl_xfer) begin
      IF_ID_Write = 1'b0;
      IF_ID_flush = 1'b1;
    end
  end

  assign stall_active = ~PCWrite;
  assign watchdog_err = watchdog_err_q;

  // Next state: a mult/div in EX starts the freeze regardless of the RUN sub-case.
  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    case (state_q)
      RUN: begin
        if (mdu_start && (MDU_LATENCY > 0)) begin
          state_d   = MDU_WAIT;
          mdu_cnt_d = MDU_LOAD;
        end
      end
      MDU_WAIT: begin
        if (mdu_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          mdu_cnt_d = mdu_cnt_q - MCW'(1);
        end
      end
      default: begin
        state_d   = RUN;
        mdu_cnt_d = '0;
      end
    endcase
  end

  // Watchdog: count consecutive RUN stall cycles, latch the error when the limit is reached.
  always_comb begin
    wd_cnt_d       = '0;
    watchdog_err_d = watchdog_err_q;
    if (stall_case) begin
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WDW'(1);
      if (wd_cnt_d == WD_MAX) begin
        watchdog_err_d = 1'b1;
      end
    end
  end

  // Sequencer and watchdog state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= RUN;
      mdu_cnt_q      <= '0;
      wd_cnt_q       <= '0;
      watchdog_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mdu_cnt_q      <= mdu_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      watchdog_err_q <= watchdog_err_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Saturating event counters for cycles with the PC held and cycles with IF/ID flushed.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!PCWrite && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (IF_ID_flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // Counter registers; reset holds them at zero so reset cycles are never counted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
